// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall controller: per-latch enable and clear, PC control,
// data-memory wait tracking with timeout, and stall/flush statistics.
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             stg_clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rd_memory,
   input  logic             ex_save_to_reg,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_ena,
   output logic             pc_sel_branch,
   output logic             ifid_ena,
   output logic             ifid_x,
   output logic             idex_ena,
   output logic             idex_x,
   output logic             exmem_ena,
   output logic             exmem_x,
   output logic             memwb_ena,
   output logic             memwb_x,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_err
);

   typedef enum logic [1:0] {START, RUN, MEM_WAIT, HALT} state_t;

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lu_block;
   logic              load_use, mem_stall_run, wait_stall, any_mem_stall;
   logic              br_flush, lu_stall;

   assign load_use = ex_rd_memory & ex_save_to_reg & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd)));

   // Priority: memory wait, then branch flush, then load-use.
   assign mem_stall_run = (state == RUN) & mem_req & ~mem_ready;
   assign wait_stall    = (state == MEM_WAIT) & ~mem_ready;
   assign any_mem_stall = mem_stall_run | wait_stall;
   assign br_flush      = (state == RUN) & ~mem_stall_run & ex_branch_taken;
   // lu_block suppresses a repeat stall: the bubble just inserted now sits in EX.
   assign lu_stall      = (state == RUN) & ~mem_stall_run & ~ex_branch_taken &
                          load_use & ~lu_block;

   always_comb begin
      pc_ena        = 1'b0;
      pc_sel_branch = 1'b0;
      ifid_ena      = 1'b0;
      ifid_x        = 1'b0;
      idex_ena      = 1'b0;
      idex_x        = 1'b0;
      exmem_ena     = 1'b0;
      exmem_x       = 1'b0;
      memwb_ena     = 1'b0;
      memwb_x       = 1'b0;
      case (state)
         START: begin
            ifid_x  = 1'b1;
            idex_x  = 1'b1;
            exmem_x = 1'b1;
            memwb_x = 1'b1;
         end
         RUN, MEM_WAIT: begin
            if (any_mem_stall) begin
               memwb_ena = 1'b1;
               memwb_x   = 1'b1;
            end else begin
               pc_ena    = ~lu_stall;
               ifid_ena  = ~lu_stall;
               idex_ena  = 1'b1;
               exmem_ena = 1'b1;
               memwb_ena = 1'b1;
               if (br_flush) begin
                  pc_sel_branch = 1'b1;
                  ifid_x        = 1'b1;
                  idex_x        = 1'b1;
               end else if (lu_stall) begin
                  idex_x = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge stg_clk or negedge reset) begin
      if (!reset) begin
         state     <= START;
         wait_cnt  <= '0;
         lu_block  <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         mem_err   <= 1'b0;
      end else begin
         lu_block <= lu_stall;
         if ((lu_stall || any_mem_stall) && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
         case (state)
            START: state <= RUN;
            RUN: begin
               if (mem_stall_run) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state <= RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= HALT;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, branch, memory wait,
// timeout/HALT and counter saturation (second instance with 2-bit counters).
module tb_pipe_ctrl;

   logic       stg_clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_rd_memory, ex_save_to_reg;
   logic       ex_branch_taken, mem_req, mem_ready;
   logic       pc_ena, pc_sel_branch, ifid_ena, ifid_x, idex_ena, idex_x;
   logic       exmem_ena, exmem_x, memwb_ena, memwb_x, mem_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic       s_pc_ena, s_pc_sel, s_ifid_ena, s_ifid_x, s_idex_ena, s_idex_x;
   logic       s_exmem_ena, s_exmem_x, s_memwb_ena, s_memwb_x, s_mem_err;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // {pc_ena, pc_sel_branch, ifid_ena, ifid_x, idex_ena, idex_x, exmem_ena, exmem_x, memwb_ena, memwb_x}
   localparam logic [9:0] C_RST  = 10'b00_01_01_01_01;
   localparam logic [9:0] C_RUN  = 10'b10_10_10_10_10;
   localparam logic [9:0] C_LU   = 10'b00_00_11_10_10;
   localparam logic [9:0] C_BR   = 10'b11_11_11_10_10;
   localparam logic [9:0] C_MEM  = 10'b00_00_00_00_11;
   localparam logic [9:0] C_HALT = 10'b00_00_00_00_00;

   wire [9:0] ctrl = {pc_ena, pc_sel_branch, ifid_ena, ifid_x, idex_ena, idex_x,
                      exmem_ena, exmem_x, memwb_ena, memwb_x};

   always #5 stg_clk = ~stg_clk;

   pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .stg_clk(stg_clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_save_to_reg(ex_save_to_reg),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_ena(pc_ena), .pc_sel_branch(pc_sel_branch), .ifid_ena(ifid_ena), .ifid_x(ifid_x),
      .idex_ena(idex_ena), .idex_x(idex_x), .exmem_ena(exmem_ena), .exmem_x(exmem_x),
      .memwb_ena(memwb_ena), .memwb_x(memwb_x),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err));

   pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
      .stg_clk(stg_clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_save_to_reg(ex_save_to_reg),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_ena(s_pc_ena), .pc_sel_branch(s_pc_sel), .ifid_ena(s_ifid_ena), .ifid_x(s_ifid_x),
      .idex_ena(s_idex_ena), .idex_x(s_idex_x), .exmem_ena(s_exmem_ena), .exmem_x(s_exmem_x),
      .memwb_ena(s_memwb_ena), .memwb_x(s_memwb_x),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .mem_err(s_mem_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge stg_clk);
      #1;
   endtask

   task automatic clr;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_rs1_used = 0; id_rs2_used = 0; ex_rd_memory = 0; ex_save_to_reg = 0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   // Load-use via rs2 against ex_rd
   task automatic set_lu(input logic [4:0] rd);
      ex_rd = rd; ex_rd_memory = 1; ex_save_to_reg = 1; id_rs2 = rd; id_rs2_used = 1;
   endtask

   initial begin
      clr();
      reset = 1'b0;
      #3;
      chk("reset_ctrl", 32'(ctrl), 32'(C_RST));
      chk("reset_stall", 32'(stall_cnt), 0);
      chk("reset_err", 32'(mem_err), 0);
      repeat (2) @(posedge stg_clk);
      @(negedge stg_clk); reset = 1'b1; #1;
      chk("start_ctrl", 32'(ctrl), 32'(C_RST));
      tick();
      chk("run_ctrl", 32'(ctrl), 32'(C_RUN));

      // load-use on rs2: one bubble only, even with the stimulus held
      set_lu(5'd5); #1;
      chk("lu_ctrl", 32'(ctrl), 32'(C_LU));
      tick();
      chk("lu_cnt", 32'(stall_cnt), 1);
      chk("lu_once", 32'(ctrl), 32'(C_RUN));
      tick();
      clr();
      set_lu(5'd0); #1;
      chk("lu_rd0", 32'(ctrl), 32'(C_RUN));
      tick();
      chk("lu_rd0_cnt", 32'(stall_cnt), 1);

      // load-use on rs1, gated by rs1_used
      clr();
      ex_rd = 5'd7; ex_rd_memory = 1; ex_save_to_reg = 1; id_rs1 = 5'd7; id_rs2 = 5'd3; id_rs2_used = 1;
      #1 chk("rs1_unused", 32'(ctrl), 32'(C_RUN));
      id_rs1_used = 1;
      #1 chk("rs1_lu", 32'(ctrl), 32'(C_LU));
      tick();
      clr(); #1;
      chk("rs1_cnt", 32'(stall_cnt), 2);

      // branch, then branch with simultaneous load-use
      ex_branch_taken = 1; #1;
      chk("br_ctrl", 32'(ctrl), 32'(C_BR));
      tick();
      chk("br_cnt", 32'(flush_cnt), 1);
      set_lu(5'd9); #1;
      chk("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
      tick();
      chk("br_lu_flush", 32'(flush_cnt), 2);
      chk("br_lu_stall", 32'(stall_cnt), 2);
      clr();

      // memory wait: 3 stall cycles (branch ignored), resume on mem_ready
      mem_req = 1; ex_branch_taken = 1; #1;
      chk("mem_s1", 32'(ctrl), 32'(C_MEM));
      tick();
      chk("mem_s2", 32'(ctrl), 32'(C_MEM));
      tick();
      chk("mem_s3", 32'(ctrl), 32'(C_MEM));
      tick();
      mem_ready = 1; #1;
      chk("mem_resume", 32'(ctrl), 32'(C_RUN));
      tick();
      clr(); #1;
      chk("mem_run", 32'(ctrl), 32'(C_RUN));
      chk("mem_stall_cnt", 32'(stall_cnt), 5);
      chk("mem_flush_cnt", 32'(flush_cnt), 2);

      // request completing the same cycle: no stall
      mem_req = 1; mem_ready = 1; #1;
      chk("mem_fast", 32'(ctrl), 32'(C_RUN));
      tick();
      clr(); #1;
      chk("mem_fast_cnt", 32'(stall_cnt), 5);

      // saturation in the 2-bit instance
      chk("sat_stall", 32'(s_stall_cnt), 3);
      set_lu(5'd4); tick(); clr(); #1;
      chk("sat_stall_hold", 32'(s_stall_cnt), 3);
      chk("wide_stall", 32'(stall_cnt), 6);
      ex_branch_taken = 1; tick(); tick(); clr(); #1;
      chk("sat_flush", 32'(s_flush_cnt), 3);
      chk("wide_flush", 32'(flush_cnt), 4);

      // timeout: 4 MEM_WAIT cycles without mem_ready -> HALT
      mem_req = 1;
      tick();
      repeat (3) tick();
      chk("to_pre_ctrl", 32'(ctrl), 32'(C_MEM));
      chk("to_pre_err", 32'(mem_err), 0);
      tick();
      chk("halt_ctrl", 32'(ctrl), 32'(C_HALT));
      chk("halt_err", 32'(mem_err), 1);
      chk("halt_stall", 32'(stall_cnt), 11);
      ex_branch_taken = 1; mem_ready = 1; set_lu(5'd2);
      tick();
      chk("halt_stay", 32'(ctrl), 32'(C_HALT));
      chk("halt_flush", 32'(flush_cnt), 4);

      // reset out of HALT
      reset = 1'b0; #1;
      chk("rst2_ctrl", 32'(ctrl), 32'(C_RST));
      chk("rst2_err", 32'(mem_err), 0);
      chk("rst2_cnt", 32'(stall_cnt), 0);
      clr();
      @(negedge stg_clk); reset = 1'b1; #1;
      chk("start2_ctrl", 32'(ctrl), 32'(C_RST));
      tick();
      chk("run2_ctrl", 32'(ctrl), 32'(C_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
